// File: rtl/hht_pkg.sv
// Shared constants and types for the HHT memory responder and the control engine.
// Register-file index map is common to both sides of the request interface.
package hht_pkg;

  localparam int unsigned DEFAULT_DATA = 99999;

  localparam logic [4:0] RF_COL_BASE = 5'd6;
  localparam logic [4:0] RF_VAL_BASE = 5'd8;
  localparam logic [4:0] RF_MAT_BASE = 5'd9;
  localparam logic [4:0] RF_ROW_BASE = 5'd15;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

endpackage

// File: rtl/hht_rd_port.sv
// Registered read stage with range check: one-cycle latency, one request per cycle.
// No backpressure; out-of-range requests return DEFAULT_DATA and raise a same-cycle oor pulse.
module hht_rd_port #(
  parameter int          DATA_W       = 32,
  parameter int          ADDR_W       = 32,
  parameter int          MEM_DEPTH    = 256,
  parameter int unsigned DEFAULT_DATA = 99999
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] word,
  output logic [DATA_W-1:0] data,
  output logic              vld,
  output logic              oor
);

  assign oor = rd_en && (addr >= ADDR_W'(MEM_DEPTH));

  // data holds its last value when no request is presented
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data <= '0;
      vld  <= 1'b0;
    end else begin
      vld <= rd_en;
      if (rd_en) begin
        data <= oor ? DATA_W'(DEFAULT_DATA) : word;
      end
    end
  end

endmodule

// File: rtl/hht_mem_responder.sv
// Memory-side responder for the HHT control engine: two 1-cycle read ports plus combinational base-register lookups.
// After reset the array is filled with DEFAULT_DATA for MEM_DEPTH cycles; requests and writes are ignored while busy.
module hht_mem_responder #(
  parameter int          DATA_W       = 32,
  parameter int          ADDR_W       = 32,
  parameter int          MEM_DEPTH    = 256,
  parameter int unsigned DEFAULT_DATA = hht_pkg::DEFAULT_DATA
) (
  input  logic              Clk,
  input  logic              Rst,
  output logic              busy,
  input  logic              rd_en1,
  input  logic [ADDR_W-1:0] addr1,
  output logic [DATA_W-1:0] dataIn1,
  output logic              rd_vld1,
  input  logic              rd_en2,
  input  logic [ADDR_W-1:0] addr2,
  output logic [DATA_W-1:0] dataIn2,
  output logic              rd_vld2,
  input  logic [4:0]        regaddr1,
  input  logic [4:0]        regaddr2,
  output logic [DATA_W-1:0] base_dat_a,
  output logic [DATA_W-1:0] base_dat_b,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_rf_wr,
  input  logic [4:0]        cpu_rf_addr,
  input  logic [DATA_W-1:0] cpu_rf_wdata,
  output logic              oor_err
);
  import hht_pkg::*;

  localparam int IDX_W = $clog2(MEM_DEPTH);

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   clr_cnt;
  logic [DATA_W-1:0]  mem [MEM_DEPTH];
  logic [DATA_W-1:0]  rf  [32];

  logic               rd_go1, rd_go2;
  logic               oor1, oor2;
  logic               cpu_wr_go, cpu_wr_oor;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == CLEAR && clr_cnt == IDX_W'(MEM_DEPTH - 1)) begin
      state_nxt = READY;
    end
  end

  always_comb begin
    busy = (state == CLEAR);
  end

  assign rd_go1     = rd_en1 && !busy;
  assign rd_go2     = rd_en2 && !busy;
  assign cpu_wr_go  = cpu_wr && !busy;
  assign cpu_wr_oor = cpu_wr_go && (cpu_addr >= ADDR_W'(MEM_DEPTH));

  // Upper address bits only feed the range check; the low bits index the array
  always_ff @(posedge Clk) begin
    if (Rst) begin
      if (busy) begin
        mem[clr_cnt] <= DATA_W'(DEFAULT_DATA);
      end else if (cpu_wr_go && !cpu_wr_oor) begin
        mem[cpu_addr[IDX_W-1:0]] <= cpu_wdata;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      for (int i = 0; i < 32; i++) begin
        rf[i] <= '0;
      end
    end else if (cpu_rf_wr && !busy) begin
      rf[cpu_rf_addr] <= cpu_rf_wdata;
    end
  end

  assign base_dat_a = rf[regaddr1];
  assign base_dat_b = rf[regaddr2];

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      oor_err <= 1'b0;
    end else if (oor1 || oor2 || cpu_wr_oor) begin
      oor_err <= 1'b1;
    end
  end

  hht_rd_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH), .DEFAULT_DATA(DEFAULT_DATA)
  ) u_rd_port1 (
    .clk   (Clk),
    .rst_n (Rst),
    .rd_en (rd_go1),
    .addr  (addr1),
    .word  (mem[addr1[IDX_W-1:0]]),
    .data  (dataIn1),
    .vld   (rd_vld1),
    .oor   (oor1)
  );

  hht_rd_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH), .DEFAULT_DATA(DEFAULT_DATA)
  ) u_rd_port2 (
    .clk   (Clk),
    .rst_n (Rst),
    .rd_en (rd_go2),
    .addr  (addr2),
    .word  (mem[addr2[IDX_W-1:0]]),
    .data  (dataIn2),
    .vld   (rd_vld2),
    .oor   (oor2)
  );

endmodule

// File: doc/hht_mem_responder.md
Name: hht_mem_responder

Overview:
- Memory-side responder for the HHT `control` engine. It is the other end of the engine's request interface.
- Serves two read ports (addr1→dataIn1, addr2→dataIn2) from an internal word array.
- Serves two base-register lookups (regaddr1→base_dat_a, regaddr2→base_dat_b) from a 32-entry register file.
- The CPU loads both the array and the register file through a write port before HHT runs.

Parameters:
- DATA_W, 32, data word width
- ADDR_W, 32, request address width
- MEM_DEPTH, 256, words in the array; legal addresses are 0..MEM_DEPTH-1
- DEFAULT_DATA, 99999, value returned for cleared or out-of-range words

Ports:
- Clk  in  1  clock, rising edge
- Rst  in  1  synchronous, active-low reset
- busy  out  1  high while the clear FSM runs
- rd_en1  in  1  port-1 read request
- addr1  in  ADDR_W  port-1 word address
- dataIn1  out  DATA_W  port-1 read data
- rd_vld1  out  1  port-1 data valid
- rd_en2  in  1  port-2 read request
- addr2  in  ADDR_W  port-2 word address
- dataIn2  out  DATA_W  port-2 read data
- rd_vld2  out  1  port-2 data valid
- regaddr1  in  5  register-file index, lookup A
- regaddr2  in  5  register-file index, lookup B
- base_dat_a  out  DATA_W  register-file data for regaddr1
- base_dat_b  out  DATA_W  register-file data for regaddr2
- cpu_wr  in  1  array write strobe
- cpu_addr  in  ADDR_W  array write address
- cpu_wdata  in  DATA_W  array write data
- cpu_rf_wr  in  1  register-file write strobe
- cpu_rf_addr  in  5  register-file write index
- cpu_rf_wdata  in  DATA_W  register-file write data
- oor_err  out  1  sticky out-of-range flag

Behaviour:
- Reset (Rst=0 at a rising edge):
  - dataIn1, dataIn2, rd_vld1, rd_vld2 and oor_err go to 0.
  - All 32 register-file entries go to 0.
  - busy=1 and the FSM enters CLEAR with clr_cnt=0.
  - Reset asserted mid-clear or mid-read does the same: clr_cnt restarts at 0 and any in-flight valid is dropped.
- FSM states: CLEAR, READY.
  - CLEAR: each cycle writes DEFAULT_DATA to mem[clr_cnt] and increments clr_cnt.
  - When clr_cnt==MEM_DEPTH-1 is written, the FSM goes to READY on the next edge; busy falls at that edge.
  - CLEAR therefore lasts exactly MEM_DEPTH cycles after reset release.
  - READY is terminal until the next reset.
- While busy=1:
  - rd_en1, rd_en2, cpu_wr and cpu_rf_wr are ignored.
  - rd_vld1 and rd_vld2 stay 0.
- Read ports are independent and identical, with 1-cycle latency.
  - rd_enN=1 at edge k gives dataInN and rd_vldN=1 during cycle k+1.
  - rd_enN=0 drops rd_vldN on the next edge; dataInN holds its last value.
  - Back-to-back requests are accepted every cycle, giving full throughput with no stalls.
- Out-of-range read (addrN >= MEM_DEPTH):
  - Returns DEFAULT_DATA with rd_vldN=1.
  - Sets oor_err, which stays set until reset.
- Out-of-range cpu_wr:
  - The write is dropped and oor_err is set.
- Both ports may request the same address in the same cycle; both return identical data.
- Read/write collision: cpu_wr to address X in the same cycle as a read of X returns the old word (read-before-write). The new word is visible from the next request onward.
- Register file:
  - Read is combinational: base_dat_a=rf[regaddr1] and base_dat_b=rf[regaddr2], with zero latency.
  - Write takes effect at the edge; a same-cycle lookup shows the old value.
- cpu_wr and cpu_rf_wr may assert in the same cycle; both commit.
- Only the low log2(MEM_DEPTH) address bits index the array. The upper bits are used only for the range check.

Decomposition:
- Package hht_pkg holds:
  - DEFAULT_DATA
  - state enum {CLEAR, READY}
  - register-file index constants RF_COL_BASE=6, RF_VAL_BASE=8, RF_MAT_BASE=9, RF_ROW_BASE=15, shared with `control`
- One sub-module, hht_rd_port: the registered read stage (enable, range check, data/valid registers, oor pulse). It is instantiated twice.
- The FSM, array and register file stay in the top level.

Test Plan:
1. Reset release → busy stays high for exactly 256 cycles. Then rd_en1 with addr1=10 → next cycle dataIn1=99999 and rd_vld1=1.
2. Load mem[180..183]={5,15,6,12} and mem[2]=33. Issue addr1=180,181,182,183 back-to-back with addr2=2 held → dataIn1 sequence 5,15,6,12 on consecutive cycles with rd_vld1 continuously 1, and dataIn2=33 each cycle.
3. cpu_rf_wr writes rf[6]=180 and rf[8]=2. Set regaddr1=6, then 8 → base_dat_a=180, then 2, in the same cycle each index is applied. regaddr2=9 (never written) → 0.
4. mem[50]=7, then cpu_wr mem[50]=9 in the same cycle as rd_en1 with addr1=50 → dataIn1=7. A repeat read → 9.
5. addr2=300 read → dataIn2=99999, rd_vld2=1, oor_err=1. oor_err is still 1 after 20 more in-range reads.
6. Assert Rst for one cycle at clr_cnt≈100, then release → busy stays high for another full 256 cycles and mem[150] reads 99999.
